add_reduction_tree: RTL and testbench
=====================================

Name: add_reduction_tree

Overview:
- Parametrised, fully pipelined reduction of ADDENDS signed lanes to one word; successor to the fixed 8-lane adder tree.
- Adds per-vector mode (sum, min, max, sum-accumulate), valid tracking, overflow detection with optional saturation, and a running accumulator.
- Hooks to a group of write ports; the result is read back as a memory-mapped read value.
- Accepts one vector per cycle; results leave in order.

Parameters:
- WORD_WIDTH, 36: lane and result width, signed two's complement.
- ADDENDS, 8: lane count; power of two, at least 2.
- LEVELS, clog2(ADDENDS): tree depth; derived, not overridden.
- SATURATE, 1: 1 clamps out-of-range sum results to the signed range; 0 wraps them to WORD_WIDTH bits.
- ACC_EXTRA, 8: accumulator guard bits above WORD_WIDTH+LEVELS.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  addends, mode and acc_clear are valid this cycle.
- mode  in  2  00 sum, 01 min, 10 max, 11 sum-accumulate.
- acc_clear  in  1  mode 11 only: zero the accumulator before adding this vector.
- addends  in  ADDENDS*WORD_WIDTH  lane i is bits [i*WORD_WIDTH +: WORD_WIDTH].
- out_valid  out  1  reduction and overflow are valid this cycle.
- reduction  out  WORD_WIDTH  result.
- overflow  out  1  result was clamped (SATURATE=1) or wrapped (SATURATE=0).

Behaviour:
- Reset (reset_n low, asynchronous): all pipeline valid bits, out_valid, reduction, overflow and the accumulator go to 0 immediately. Data registers also reset to 0. Release is synchronous to clock.
- Pipeline: input register, then LEVELS tree stages, then output stage.
- Latency is LEVELS+2 cycles from in_valid to out_valid; 5 cycles for ADDENDS=8.
- Throughput is one vector per cycle. There is no backpressure and no stall.
- mode and acc_clear travel with their vector. Mode may change every cycle without corrupting in-flight vectors.
- in_valid low inserts a bubble; the bubble reaches out_valid low LEVELS+2 cycles later.
- When out_valid is low, reduction and overflow hold their last values.
- Tree pairing: level k combines element 2j with element 2j+1.
- Sum widths: level k holds WORD_WIDTH+k bits, so no intermediate overflow occurs.
- Min/max: signed compare at each level, WORD_WIDTH bits throughout; overflow is always 0.
- Sum (00) output stage: the full-width sum S is range-checked against the signed WORD_WIDTH range.
  - Out of range: overflow=1; reduction is the clamped value (SATURATE=1) or S[WORD_WIDTH-1:0] (SATURATE=0).
- Sum-accumulate (11) output stage:
  - acc_next = (acc_clear ? 0 : acc) + sign-extended S; acc <= acc_next.
  - reduction and overflow are derived from acc_next using the same range rule as sum.
  - The accumulator (WORD_WIDTH+LEVELS+ACC_EXTRA bits) wraps internally.
- The accumulator changes only on a valid mode-11 vector. Bubbles and modes 00/01/10 leave it untouched.
- acc_clear outside mode 11 is ignored.
- Reset mid-operation: in-flight vectors are discarded. No out_valid pulse from pre-reset data occurs after release.

Decomposition:
- Shared package:
  - mode encodings MODE_SUM, MODE_MIN, MODE_MAX, MODE_ACC;
  - a clog2 function;
  - a signed saturate/range-check function (width in, WORD_WIDTH out, overflow flag).
- Sub-module reduction_tree_stage, one registered tree level, parameterised by input element count and element width. It carries valid, mode and acc_clear and is instantiated LEVELS times from a generate loop.

Test Plan:
- Sum, ADDENDS=8, WORD_WIDTH=36, lanes 1..8, single in_valid pulse -> out_valid exactly 5 cycles later, reduction=36, overflow=0.
- Min then max on consecutive cycles, lanes {5,-3,7,0,2,-1,6,4} -> reduction -3 then 7 on consecutive cycles, overflow=0.
- All lanes 2^35-1, sum mode:
  - SATURATE=1 -> reduction=2^35-1, overflow=1;
  - SATURATE=0 -> reduction=-8, overflow=1.
- Mode 11, acc_clear=1 on the first vector, vector sums 10, 20, 30 back-to-back -> outputs 10, 30, 60. An interleaved mode-00 vector (sum 7) -> outputs 7 and leaves the accumulator at 60. A following mode-11 vector with acc_clear=1 and sum 5 -> output 5.
- Continuous in_valid with a bubble every third cycle and random modes/lanes -> results match a reference model in order, with bubble gaps reproduced.
- reset_n low for 1 cycle with 3 vectors in flight and acc=60:
  - out_valid, reduction and acc go to 0 asynchronously;
  - no stale out_valid appears after release;
  - the next mode-11 vector with sum 4 and acc_clear=0 -> output 4.

Source files
------------

// File: rtl/add_reduction_tree_pkg.sv
// Shared definitions for the signed lane reduction tree: mode encodings,
// a constant log2 helper and the signed range check used by the output stage.
package add_reduction_tree_pkg;

    typedef enum logic [1:0] {
        MODE_SUM = 2'b00,
        MODE_MIN = 2'b01,
        MODE_MAX = 2'b10,
        MODE_ACC = 2'b11
    } mode_e;

    localparam int SAT_MAX_W = 128;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W-1:0] value;
    } sat_result_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) r++;
        return r;
    endfunction

    // Caller keeps the low out_width bits; without saturation they are the wrapped value.
    function automatic sat_result_t range_check(input logic signed [SAT_MAX_W-1:0] value,
                                                input int unsigned out_width,
                                                input logic saturate);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_result_t res;
        hi = $signed((SAT_MAX_W'(1) << (out_width - 1)) - SAT_MAX_W'(1));
        lo = ~hi;
        res.ovf = (value > hi) || (value < lo);
        if (res.ovf && saturate) res.value = value[SAT_MAX_W-1] ? lo : hi;
        else                     res.value = value;
        return res;
    endfunction

endpackage

// File: rtl/reduction_tree_stage.sv
// One registered tree level: pairs element 2j with 2j+1 by add, min or max,
// widening by one bit; valid, mode and acc_clear ride along with the data.
module reduction_tree_stage
    import add_reduction_tree_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int EW   = 36
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [1:0]                   mode,
    input  logic                         acc_clear,
    input  logic [N_IN*EW-1:0]           data_in,
    output logic                         out_valid,
    output logic [1:0]                   out_mode,
    output logic                         out_acc_clear,
    output logic [(N_IN/2)*(EW+1)-1:0]   data_out
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*(EW+1)-1:0] data_next;
    logic signed [EW-1:0]    a;
    logic signed [EW-1:0]    b;

    // Min/max results are sign-extended so one datapath serves every mode.
    always_comb begin
        data_next = '0;
        a = '0;
        b = '0;
        for (int j = 0; j < N_OUT; j++) begin
            a = data_in[(2*j)*EW +: EW];
            b = data_in[(2*j+1)*EW +: EW];
            case (mode)
                MODE_MIN: data_next[j*(EW+1) +: EW+1] = (a < b) ? (EW+1)'(a) : (EW+1)'(b);
                MODE_MAX: data_next[j*(EW+1) +: EW+1] = (a > b) ? (EW+1)'(a) : (EW+1)'(b);
                default:  data_next[j*(EW+1) +: EW+1] = (EW+1)'(a) + (EW+1)'(b);
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_mode      <= 2'b00;
            out_acc_clear <= 1'b0;
            data_out      <= '0;
        end else begin
            out_valid     <= in_valid;
            out_mode      <= mode;
            out_acc_clear <= acc_clear;
            data_out      <= data_next;
        end
    end

endmodule

// File: rtl/add_reduction_tree.sv
// Pipelined signed reduction of ADDENDS lanes: input register, LEVELS tree
// stages, then an output stage with range check, saturation and accumulator.
module add_reduction_tree
    import add_reduction_tree_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int ADDENDS    = 8,
    parameter int SATURATE   = 1,
    parameter int ACC_EXTRA  = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [1:0]                    mode,
    input  logic                          acc_clear,
    input  logic [ADDENDS*WORD_WIDTH-1:0] addends,
    output logic                          out_valid,
    output logic [WORD_WIDTH-1:0]         reduction,
    output logic                          overflow
);

    localparam int LEVELS = clog2(ADDENDS);
    localparam int SUM_W  = WORD_WIDTH + LEVELS;
    localparam int ACC_W  = SUM_W + ACC_EXTRA;

    logic                          in_valid_q;
    logic [1:0]                    mode_q;
    logic                          acc_clear_q;
    logic [ADDENDS*WORD_WIDTH-1:0] addends_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_valid_q  <= 1'b0;
            mode_q      <= 2'b00;
            acc_clear_q <= 1'b0;
            addends_q   <= '0;
        end else begin
            in_valid_q  <= in_valid;
            mode_q      <= mode;
            acc_clear_q <= acc_clear;
            addends_q   <= addends;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int N_IN = ADDENDS >> k;
        localparam int EW   = WORD_WIDTH + k;
        logic                       v;
        logic [1:0]                 m;
        logic                       c;
        logic [(N_IN/2)*(EW+1)-1:0] d;
        if (k == 0) begin : g_first
            reduction_tree_stage #(.N_IN(N_IN), .EW(EW)) u_stage (
                .clock(clock), .reset_n(reset_n),
                .in_valid(in_valid_q), .mode(mode_q), .acc_clear(acc_clear_q), .data_in(addends_q),
                .out_valid(v), .out_mode(m), .out_acc_clear(c), .data_out(d)
            );
        end else begin : g_next
            reduction_tree_stage #(.N_IN(N_IN), .EW(EW)) u_stage (
                .clock(clock), .reset_n(reset_n),
                .in_valid(g_level[k-1].v), .mode(g_level[k-1].m),
                .acc_clear(g_level[k-1].c), .data_in(g_level[k-1].d),
                .out_valid(v), .out_mode(m), .out_acc_clear(c), .data_out(d)
            );
        end
    end

    logic                     tree_valid;
    logic [1:0]               tree_mode;
    logic                     tree_clr;
    logic signed [SUM_W-1:0]  tree_sum;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    sat_result_t              sum_chk;
    sat_result_t              acc_chk;
    logic [WORD_WIDTH-1:0]    red_next;
    logic                     ovf_next;
    logic                     unused_chk_bits;

    assign tree_valid = g_level[LEVELS-1].v;
    assign tree_mode  = g_level[LEVELS-1].m;
    assign tree_clr   = g_level[LEVELS-1].c;
    assign tree_sum   = g_level[LEVELS-1].d;

    // Only the low WORD_WIDTH bits of a checked value leave the block.
    assign unused_chk_bits = ^{sum_chk.value[SAT_MAX_W-1:WORD_WIDTH], acc_chk.value[SAT_MAX_W-1:WORD_WIDTH]};

    always_comb begin
        acc_next = (tree_clr ? ACC_W'(0) : acc) + ACC_W'(tree_sum);
        sum_chk  = range_check(SAT_MAX_W'(tree_sum), WORD_WIDTH, SATURATE != 0);
        acc_chk  = range_check(SAT_MAX_W'(acc_next), WORD_WIDTH, SATURATE != 0);
        red_next = tree_sum[WORD_WIDTH-1:0];
        ovf_next = 1'b0;
        case (tree_mode)
            MODE_SUM: begin
                red_next = sum_chk.value[WORD_WIDTH-1:0];
                ovf_next = sum_chk.ovf;
            end
            MODE_ACC: begin
                red_next = acc_chk.value[WORD_WIDTH-1:0];
                ovf_next = acc_chk.ovf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            reduction <= '0;
            overflow  <= 1'b0;
            acc       <= '0;
        end else if (tree_valid) begin
            out_valid <= 1'b1;
            reduction <= red_next;
            overflow  <= ovf_next;
            if (tree_mode == MODE_ACC) acc <= acc_next;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_reduction_tree.sv
// Self-checking bench: two instances (saturating and wrapping) driven in lockstep,
// checked against constants and an arithmetic reference model of the reduction.
module tb_add_reduction_tree;

    localparam int W     = 36;
    localparam int N     = 8;
    localparam int LAT   = 5;
    localparam int DEPTH = 2048;
    localparam longint MAXV = (64'sd1 <<< 35) - 64'sd1;
    localparam longint MINV = -MAXV - 64'sd1;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic           acc_clear = 1'b0;
    logic [N*W-1:0] addends = '0;
    logic           out_valid0, out_valid1, ovf0, ovf1;
    logic [W-1:0]   red0, red1;

    add_reduction_tree #(.WORD_WIDTH(W), .ADDENDS(N), .SATURATE(1), .ACC_EXTRA(8)) dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .mode(mode), .acc_clear(acc_clear),
        .addends(addends), .out_valid(out_valid0), .reduction(red0), .overflow(ovf0));
    add_reduction_tree #(.WORD_WIDTH(W), .ADDENDS(N), .SATURATE(0), .ACC_EXTRA(8)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .mode(mode), .acc_clear(acc_clear),
        .addends(addends), .out_valid(out_valid1), .reduction(red1), .overflow(ovf1));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic         cv0[DEPTH], cv1[DEPTH], co0[DEPTH], co1[DEPTH];
    logic [W-1:0] cr0[DEPTH], cr1[DEPTH];
    logic         ev[DEPTH], eo0[DEPTH], eo1[DEPTH];
    logic [W-1:0] er0[DEPTH], er1[DEPTH];

    always @(negedge clock) begin
        if (cyc < DEPTH) begin
            cv0[cyc] = out_valid0; cr0[cyc] = red0; co0[cyc] = ovf0;
            cv1[cyc] = out_valid1; cr1[cyc] = red1; co1[cyc] = ovf1;
        end
    end

    int           vectors = 0;
    int           miscompares = 0;
    longint       lane_q[N];
    longint       macc = 0;
    logic [W-1:0] last_r0 = '0, last_r1 = '0;
    logic         last_o0 = 1'b0, last_o1 = 1'b0;

    function automatic longint wrap_acc(input longint x);
        return (x <<< 17) >>> 17;
    endfunction

    function automatic logic [W-1:0] to36(input longint x);
        return x[W-1:0];
    endfunction

    task automatic set_small(input longint x);
        for (int i = 0; i < N; i++) lane_q[i] = 0;
        lane_q[3] = x - 1;
        lane_q[6] = 1;
    endtask

    // Drives one cycle and records what the reference says should emerge LAT cycles later.
    task automatic send(input bit v, input logic [1:0] m, input bit clr);
        longint s, mn, mx, val, lim;
        bit ranged, ov;
        int c;
        c = cyc;
        in_valid = v; mode = m; acc_clear = clr;
        for (int i = 0; i < N; i++) addends[i*W +: W] = lane_q[i][W-1:0];
        if (v) begin
            s = 0; mn = lane_q[0]; mx = lane_q[0];
            for (int i = 0; i < N; i++) begin
                s += lane_q[i];
                if (lane_q[i] < mn) mn = lane_q[i];
                if (lane_q[i] > mx) mx = lane_q[i];
            end
            ranged = 1'b1; val = s;
            case (m)
                2'd1: begin val = mn; ranged = 1'b0; end
                2'd2: begin val = mx; ranged = 1'b0; end
                2'd3: begin macc = wrap_acc((clr ? 64'sd0 : macc) + s); val = macc; end
                default: ;
            endcase
            ov = ranged && (val > MAXV || val < MINV);
            lim = (val < 0) ? MINV : MAXV;
            last_o0 = ov; last_o1 = ov;
            last_r1 = val[W-1:0];
            last_r0 = ov ? lim[W-1:0] : val[W-1:0];
        end
        if (c + LAT < DEPTH) begin
            ev[c+LAT] = v;
            er0[c+LAT] = last_r0; eo0[c+LAT] = last_o0;
            er1[c+LAT] = last_r1; eo1[c+LAT] = last_o1;
        end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 2'b00, 1'b0);
    endtask

    task automatic test_reset;
        #2;
        vectors++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b%b want 00", out_valid0, out_valid1); end
        vectors++; if (red0 !== '0 || red1 !== '0) begin miscompares++; $display("FAIL reset_reduction: got %h/%h want 0", red0, red1); end
        vectors++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b%b want 00", ovf0, ovf1); end
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        idle(3);
    endtask

    task automatic test_sum_latency;
        int c;
        idle(6);
        for (int i = 0; i < N; i++) lane_q[i] = i + 1;
        c = cyc;
        send(1'b1, 2'b00, 1'b0);
        idle(8);
        vectors++; if (cv0[c+LAT-1] !== 1'b0) begin miscompares++; $display("FAIL sum_early_valid: got %b want 0", cv0[c+LAT-1]); end
        vectors++; if (cv0[c+LAT] !== 1'b1) begin miscompares++; $display("FAIL sum_latency_valid: got %b want 1", cv0[c+LAT]); end
        vectors++; if (cv0[c+LAT+1] !== 1'b0) begin miscompares++; $display("FAIL sum_single_pulse: got %b want 0", cv0[c+LAT+1]); end
        vectors++; if (cr0[c+LAT] !== to36(36) || co0[c+LAT] !== 1'b0) begin miscompares++; $display("FAIL sum_value: got %0d ovf %b want 36 ovf 0", $signed(cr0[c+LAT]), co0[c+LAT]); end
        vectors++; if (cr0[c+LAT+2] !== to36(36)) begin miscompares++; $display("FAIL sum_hold: got %0d want 36", $signed(cr0[c+LAT+2])); end
    endtask

    task automatic test_min_max;
        int c;
        lane_q = '{5, -3, 7, 0, 2, -1, 6, 4};
        c = cyc;
        send(1'b1, 2'b01, 1'b0);
        send(1'b1, 2'b10, 1'b0);
        idle(7);
        vectors++; if (cv0[c+LAT] !== 1'b1 || cr0[c+LAT] !== to36(-3) || co0[c+LAT] !== 1'b0) begin miscompares++; $display("FAIL min_value: got v%b %0d ovf %b want v1 -3 ovf 0", cv0[c+LAT], $signed(cr0[c+LAT]), co0[c+LAT]); end
        vectors++; if (cv0[c+LAT+1] !== 1'b1 || cr0[c+LAT+1] !== to36(7) || co0[c+LAT+1] !== 1'b0) begin miscompares++; $display("FAIL max_value: got v%b %0d ovf %b want v1 7 ovf 0", cv0[c+LAT+1], $signed(cr0[c+LAT+1]), co0[c+LAT+1]); end
    endtask

    task automatic test_overflow;
        int c;
        for (int i = 0; i < N; i++) lane_q[i] = MAXV;
        c = cyc;
        send(1'b1, 2'b00, 1'b0);
        idle(7);
        vectors++; if (cr0[c+LAT] !== to36(MAXV) || co0[c+LAT] !== 1'b1) begin miscompares++; $display("FAIL ovf_saturate: got %h ovf %b want %h ovf 1", cr0[c+LAT], co0[c+LAT], to36(MAXV)); end
        vectors++; if (cr1[c+LAT] !== to36(-8) || co1[c+LAT] !== 1'b1) begin miscompares++; $display("FAIL ovf_wrap: got %0d ovf %b want -8 ovf 1", $signed(cr1[c+LAT]), co1[c+LAT]); end
    endtask

    task automatic test_accumulate;
        int c;
        longint exp_v[6] = '{10, 30, 60, 7, 61, 5};
        c = cyc;
        set_small(10); send(1'b1, 2'b11, 1'b1);
        set_small(20); send(1'b1, 2'b11, 1'b0);
        set_small(30); send(1'b1, 2'b11, 1'b0);
        set_small(7);  send(1'b1, 2'b00, 1'b1);
        set_small(1);  send(1'b1, 2'b11, 1'b0);
        set_small(5);  send(1'b1, 2'b11, 1'b1);
        idle(7);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (cv0[c+LAT+i] !== 1'b1 || cr0[c+LAT+i] !== to36(exp_v[i]) || cr1[c+LAT+i] !== to36(exp_v[i]) || co0[c+LAT+i] !== 1'b0)
                begin miscompares++; $display("FAIL acc_step%0d: got v%b %0d/%0d ovf %b want v1 %0d ovf 0", i, cv0[c+LAT+i], $signed(cr0[c+LAT+i]), $signed(cr1[c+LAT+i]), co0[c+LAT+i], exp_v[i]); end
        end
    endtask

    task automatic test_random_bubbles;
        int start;
        bit [63:0] r;
        logic [W-1:0] x;
        start = cyc;
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < N; i++) begin
                r = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) x = r[W-1:0];
                else x = W'($urandom_range(0, 2000)) - W'(1000);
                lane_q[i] = longint'($signed(x));
            end
            send((k % 3) != 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle(7);
        for (int c = start + LAT; c < start + LAT + 60; c++) begin
            vectors++;
            if (cv0[c] !== ev[c] || cv1[c] !== ev[c] || cr0[c] !== er0[c] || co0[c] !== eo0[c] || cr1[c] !== er1[c] || co1[c] !== eo1[c])
                begin miscompares++; $display("FAIL random_cycle%0d: got v%b%b %h %b / %h %b want v%b %h %b / %h %b", c - start, cv0[c], cv1[c], cr0[c], co0[c], cr1[c], co1[c], ev[c], er0[c], eo0[c], er1[c], eo1[c]); end
        end
    endtask

    task automatic test_reset_mid;
        int c;
        set_small(60); send(1'b1, 2'b11, 1'b1);
        set_small(3);  send(1'b1, 2'b11, 1'b0);
        send(1'b1, 2'b00, 1'b0);
        send(1'b1, 2'b11, 1'b0);
        send(1'b1, 2'b01, 1'b0);
        // Tree now holds four vectors and the output shows the 60 accumulate result.
        vectors++; if (out_valid0 !== 1'b1 || red0 !== to36(60)) begin miscompares++; $display("FAIL pre_reset_output: got v%b %0d want v1 60", out_valid0, $signed(red0)); end
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid0 !== 1'b0 || red0 !== '0 || ovf0 !== 1'b0 || red1 !== '0) begin miscompares++; $display("FAIL async_reset: got v%b %h ovf %b %h want v0 0 ovf 0 0", out_valid0, red0, ovf0, red1); end
        macc = 0; last_r0 = '0; last_r1 = '0; last_o0 = 1'b0; last_o1 = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        c = cyc;
        idle(8);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (cv0[c+i] !== 1'b0 || cv1[c+i] !== 1'b0) begin miscompares++; $display("FAIL stale_valid%0d: got %b%b want 00", i, cv0[c+i], cv1[c+i]); end
        end
        set_small(4);
        c = cyc;
        send(1'b1, 2'b11, 1'b0);
        idle(7);
        vectors++; if (cv0[c+LAT] !== 1'b1 || cr0[c+LAT] !== to36(4) || cr1[c+LAT] !== to36(4)) begin miscompares++; $display("FAIL acc_after_reset: got v%b %0d/%0d want v1 4", cv0[c+LAT], $signed(cr0[c+LAT]), $signed(cr1[c+LAT])); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) lane_q[i] = 0;
        test_reset();
        test_sum_latency();
        test_min_max();
        test_overflow();
        test_accumulate();
        test_random_bubbles();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
